// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - two-write, two-read register file with a clear-sweep FSM
//
// Purpose:
//   DEPTH = 2**ADDR_W entries of DATA_W bits. There are two synchronous write
//   ports and two combinational read ports. A clear FSM (IDLE -> SWEEP -> DONE)
//   zeroes one entry per cycle. Writes are dropped while the sweep runs.
//
// Parameters:
//   DATA_W    entry width in bits
//   ADDR_W    address width; DEPTH = 2**ADDR_W
//   ZERO_REG  1 = entry 0 is hard-wired to zero
//
// Optional feature:
//   REGFILE_BYPASS_EN  When defined, a read returns the data of an accepted
//                      write to the same address in the same cycle
//                      (port 1 wins). No bypass occurs during a sweep.
//
// Ports:
//   sys_clk, sys_rst_n    clock and asynchronous active-low reset
//   we0/wa0/wd0           write port 0
//   we1/wa1/wd1           write port 1 (wins on a same-address collision)
//   ra1/rd1, ra2/rd2      combinational read ports A and B
//   clr_req               starts a clear sweep from IDLE
//   clr_busy              high while the sweep is in progress
//   clr_done              one-cycle pulse after the last entry is cleared
module regfile_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam bit ZR = (ZERO_REG != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr0_en;
  logic wr1_en;

  assign clr_busy = (state_q == SWEEP);
  assign clr_done = (state_q == DONE);

  // Writes are accepted only outside the sweep. With ZERO_REG set, writes to
  // entry 0 are dropped so that entry always stays at its reset value of 0.
  assign wr0_en = we0 && !clr_busy && !(ZR && (wa0 == '0));
  assign wr1_en = we1 && !clr_busy && !(ZR && (wa1 == '0));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        if (ptr_q == PTR_LAST) begin
          state_d = DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Port 1's write is issued after port 0's, so it wins on a shared address.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == SWEEP) begin
      mem_q[ptr_q] <= '0;
    end else begin
      if (wr0_en) mem_q[wa0] <= wd0;
      if (wr1_en) mem_q[wa1] <= wd1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // wrN_en already excludes the sweep, so no bypass happens while busy.
  always_comb begin
    rd1 = mem_q[ra1];
    if (wr0_en && (wa0 == ra1)) rd1 = wd0;
    if (wr1_en && (wa1 == ra1)) rd1 = wd1;
    if (ZR && (ra1 == '0))      rd1 = '0;
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if (wr0_en && (wa0 == ra2)) rd2 = wd0;
    if (wr1_en && (wa1 == ra2)) rd2 = wd1;
    if (ZR && (ra2 == '0))      rd2 = '0;
  end
`else
  always_comb begin
    rd1 = mem_q[ra1];
    if (ZR && (ra1 == '0)) rd1 = '0;
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if (ZR && (ra2 == '0)) rd2 = '0;
  end
`endif

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - scoreboard testbench for regfile_param
module tb_regfile_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  localparam bit BYP =
`ifdef REGFILE_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] wa0 = '0, wa1 = '0, ra1 = '0, ra2 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;
  logic [DW-1:0] rd1, rd2, z_rd1, z_rd2;
  logic          busy, done, z_busy, z_done;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .clr_req(clr_req), .clr_busy(busy), .clr_done(done)
  );

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut_z (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(z_rd1), .rd2(z_rd2),
    .clr_req(clr_req), .clr_busy(z_busy), .clr_done(z_done)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] sb_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] e;
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    total_cnt++;
    if ({busy, done, z_busy, z_done} !== 4'b0000) $display("FAIL reset_status: got %b expected 0000", {busy, done, z_busy, z_done});
    else pass_cnt++;
    for (int a = 0; a < DEPTH; a += 3) begin
      @(negedge clk);
      ra1 = AW'(a);
      ra2 = AW'(DEPTH - 1 - a);
      sb_q.push_back(exp_mem[a]);
      sb_q.push_back(exp_mem[DEPTH - 1 - a]);
      #1;
      e = sb_q.pop_front();
      total_cnt++;
      if (rd1 !== e) $display("FAIL reset_rd1 a=%0d: got %h expected %h", a, rd1, e);
      else pass_cnt++;
      e = sb_q.pop_front();
      total_cnt++;
      if (rd2 !== e) $display("FAIL reset_rd2 a=%0d: got %h expected %h", a, rd2, e);
      else pass_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_read();
    logic [DW-1:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      we0 = 1'b1; wa0 = AW'(i); wd0 = DW'(i);
      tick();
      exp_mem[i] = DW'(i);
    end
    we0 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = AW'(i); ra2 = AW'(i);
      sb_q.push_back(exp_mem[i]);
      sb_q.push_back((i == 0) ? 8'h00 : exp_mem[i]);
      #3;
      e = sb_q.pop_front();
      total_cnt++;
      if (rd1 !== e || rd2 !== e) $display("FAIL fill_read a=%0d: got %h/%h expected %h", i, rd1, rd2, e);
      else pass_cnt++;
      e = sb_q.pop_front();
      total_cnt++;
      if (z_rd1 !== e || z_rd2 !== e) $display("FAIL fill_read_zero a=%0d: got %h/%h expected %h", i, z_rd1, z_rd2, e);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_same_addr();
    logic [DW-1:0] e;
    we0 = 1'b1; wa0 = 3'd3; wd0 = 8'h11;
    we1 = 1'b1; wa1 = 3'd3; wd1 = 8'h22;
    tick();
    we0 = 1'b0; we1 = 1'b0;
    exp_mem[3] = 8'h22;
    ra1 = 3'd3;
    sb_q.push_back(exp_mem[3]);
    #3;
    e = sb_q.pop_front();
    total_cnt++;
    if (rd1 !== e) $display("FAIL same_addr: got %h expected %h", rd1, e);
    else pass_cnt++;
    total_cnt++;
    if (z_rd1 !== e) $display("FAIL same_addr_zero: got %h expected %h", z_rd1, e);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_bypass();
    logic [DW-1:0] e;
    ra1 = 3'd5; ra2 = 3'd0;
    we0 = 1'b1; wa0 = 3'd5; wd0 = 8'hA5;
    we1 = 1'b1; wa1 = 3'd0; wd1 = 8'h3C;
    sb_q.push_back(BYP ? 8'hA5 : exp_mem[5]);
    sb_q.push_back(BYP ? 8'h3C : exp_mem[0]);
    #3;
    e = sb_q.pop_front();
    total_cnt++;
    if (rd1 !== e) $display("FAIL bypass_pre_rd1: got %h expected %h", rd1, e);
    else pass_cnt++;
    e = sb_q.pop_front();
    total_cnt++;
    if (rd2 !== e) $display("FAIL bypass_pre_rd2: got %h expected %h", rd2, e);
    else pass_cnt++;
    total_cnt++;
    if (z_rd2 !== 8'h00) $display("FAIL bypass_pre_zero: got %h expected 00", z_rd2);
    else pass_cnt++;
    tick();
    we0 = 1'b0; we1 = 1'b0;
    exp_mem[5] = 8'hA5;
    exp_mem[0] = 8'h3C;
    sb_q.push_back(exp_mem[5]);
    sb_q.push_back(exp_mem[0]);
    #3;
    e = sb_q.pop_front();
    total_cnt++;
    if (rd1 !== e) $display("FAIL bypass_post_rd1: got %h expected %h", rd1, e);
    else pass_cnt++;
    e = sb_q.pop_front();
    total_cnt++;
    if (rd2 !== e) $display("FAIL bypass_post_rd2: got %h expected %h", rd2, e);
    else pass_cnt++;
    total_cnt++;
    if (z_rd2 !== 8'h00) $display("FAIL bypass_post_zero: got %h expected 00", z_rd2);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    logic [DW-1:0] e, e2;
    logic [1:0]    s;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      ra1 = AW'(k);
      ra2 = AW'((k + DEPTH - 1) % DEPTH);
      we1 = (k == 3); wa1 = 3'd2; wd1 = 8'h77;
      sb_q.push_back(exp_mem[k]);
      sb_q.push_back(exp_mem[(k + DEPTH - 1) % DEPTH]);
      sb_q.push_back(8'h02);
      #3;
      e = sb_q.pop_front();
      e2 = sb_q.pop_front();
      s = sb_q.pop_front()[1:0];
      total_cnt++;
      if ({rd1, rd2, busy, done} !== {e, e2, s})
        $display("FAIL sweep_cycle k=%0d: got rd1=%h rd2=%h busy/done=%b%b expected %h %h %b", k, rd1, rd2, busy, done, e, e2, s);
      else pass_cnt++;
      exp_mem[k] = '0;
      tick();
    end
    we1 = 1'b0;
    we0 = 1'b1; wa0 = 3'd6; wd0 = 8'h66;
    #3;
    total_cnt++;
    if ({busy, done} !== 2'b01) $display("FAIL sweep_done: got busy/done=%b%b expected 01", busy, done);
    else pass_cnt++;
    tick();
    we0 = 1'b0;
    exp_mem[6] = 8'h66;
    #3;
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL sweep_idle: got busy/done=%b%b expected 00", busy, done);
    else pass_cnt++;
    for (int a = 0; a < DEPTH; a++) begin
      ra1 = AW'(a);
      sb_q.push_back(exp_mem[a]);
      #1;
      e = sb_q.pop_front();
      total_cnt++;
      if (rd1 !== e) $display("FAIL after_clear a=%0d: got %h expected %h", a, rd1, e);
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    for (int i = 0; i < DEPTH; i += 2) begin
      we0 = 1'b1; wa0 = AW'(i);     wd0 = 8'h80 | DW'(i);
      we1 = 1'b1; wa1 = AW'(i + 1); wd1 = 8'h80 | DW'(i + 1);
      tick();
      exp_mem[i] = 8'h80 | DW'(i);
      exp_mem[i + 1] = 8'h80 | DW'(i + 1);
    end
    we0 = 1'b0; we1 = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    ra1 = 3'd5;
    #1;
    total_cnt++;
    if ({rd1, busy} !== {exp_mem[5], 1'b1}) $display("FAIL pre_abort: got rd1=%h busy=%b expected %h 1", rd1, busy, exp_mem[5]);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    total_cnt++;
    if ({busy, done, rd1} !== {2'b00, exp_mem[5]}) $display("FAIL abort_now: got busy/done=%b%b rd1=%h expected 00 00", busy, done, rd1);
    else pass_cnt++;
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      ra1 = AW'(a); ra2 = AW'(a);
      #1;
      total_cnt++;
      if (rd1 !== exp_mem[a] || rd2 !== exp_mem[a]) $display("FAIL abort_clear a=%0d: got %h/%h expected %h", a, rd1, rd2, exp_mem[a]);
      else pass_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (busy || done) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL abort_no_done: got %0d active cycles expected 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] s;
    for (int c = 0; c < 20; c++) begin
      if ((c % 10) < 8)       sb_q.push_back(8'h02);
      else if ((c % 10) == 8) sb_q.push_back(8'h01);
      else                    sb_q.push_back(8'h00);
    end
    clr_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      #2;
      s = sb_q.pop_front()[1:0];
      total_cnt++;
      if ({busy, done} !== s) $display("FAIL back_to_back c=%0d: got busy/done=%b%b expected %b", c, busy, done, s);
      else pass_cnt++;
    end
    clr_req = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    total_cnt++;
    if ({busy, done, z_busy, z_done} !== 4'b0000) $display("FAIL back_to_back_end: got %b expected 0000", {busy, done, z_busy, z_done});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_same_addr();
    test_bypass();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_W    8   entry width in bits
  ADDR_W    3   address width; DEPTH = 2**ADDR_W entries
  ZERO_REG  0   1 = entry 0 is hard-wired to zero
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  sys_clk    in   1       single clock, all state on rising edge
  sys_rst_n  in   1       asynchronous, active-low reset
  we0        in   1       write enable, port 0
  wa0        in   ADDR_W  write address, port 0
  wd0        in   DATA_W  write data, port 0
  we1        in   1       write enable, port 1
  wa1        in   ADDR_W  write address, port 1
  wd1        in   DATA_W  write data, port 1
  ra1        in   ADDR_W  read address, port A
  ra2        in   ADDR_W  read address, port B
  rd1        out  DATA_W  read data, port A
  rd2        out  DATA_W  read data, port B
  clr_req    in   1       request a full-array clear sweep
  clr_busy   out  1       sweep in progress
  clr_done   out  1       one-cycle pulse at sweep completion
REQ-003 One clock and reset is asynchronous and active-low: sys_clk and sys_rst_n.

Function
REQ-004 Reads SHALL be combinational: rd1 = mem[ra1], rd2 = mem[ra2], zero latency.
REQ-005 A write SHALL update mem[waN] with wdN at the rising edge when weN=1 and clr_busy=0.
REQ-006 If both ports write the same address in the same cycle, port 1's data SHALL be stored.
REQ-007 If ZERO_REG=1, writes to address 0 SHALL be dropped and reads of address 0 SHALL return 0.
REQ-008 The clear FSM SHALL have states IDLE, SWEEP and DONE.
REQ-009 From IDLE with clr_req=1 at an edge, the FSM SHALL enter SWEEP with pointer ptr=0.
REQ-010 In SWEEP, each edge SHALL write mem[ptr]=0 and increment ptr; at ptr=DEPTH-1 the final clear SHALL occur and the FSM SHALL enter DONE.
REQ-011 DONE SHALL last exactly one cycle and then return to IDLE; clr_req still high in IDLE SHALL start a new sweep.
REQ-012 clr_busy SHALL be (state==SWEEP), high for exactly DEPTH cycles; clr_done SHALL be (state==DONE), high for exactly one cycle; both SHALL be registered-state decodes.
REQ-013 clr_req SHALL be ignored in SWEEP and DONE.
REQ-014 Writes presented while clr_busy=1 SHALL be dropped, not queued; writes in DONE SHALL be accepted.
REQ-015 Reads during SWEEP SHALL return current array contents: cleared entries read 0, uncleared entries read their old value.

Reset
REQ-016 sys_rst_n=0 SHALL immediately, without a clock, clear all entries to 0, set state=IDLE, ptr=0, clr_busy=0 and clr_done=0.
REQ-017 Reset asserted mid-sweep SHALL abort the sweep, and clr_done SHALL NOT pulse for the aborted sweep.

Configuration
REQ-018 With macro REGFILE_BYPASS_EN defined, a read whose address matches an accepted same-cycle write SHALL return that write's data combinationally, using port 1 on a double match; ZERO_REG still forces address 0 to 0, and no bypass SHALL occur while clr_busy=1.
REQ-019 Without REGFILE_BYPASS_EN, reads SHALL return only stored contents, and a new value SHALL become visible the cycle after the write edge.

Verification (DATA_W=8, ADDR_W=3)
REQ-020 Release reset, then write i to address i via port 0 for i=0..7, then sweep ra1=ra2=i -> rd1=rd2=i; with ZERO_REG=1, address 0 reads 0x00.
REQ-021 Same cycle: we0/wa0=3/wd0=0x11 and we1/wa1=3/wd1=0x22 -> next cycle, ra1=3 gives rd1=0x22.
REQ-022 mem[5]=0x05; drive we0/wa0=5/wd0=0xA5 with ra1=5 in the same cycle -> with the macro, rd1=0xA5 before the edge; without it, rd1=0x05 until after the edge.
REQ-023 Filled array, one-cycle clr_req -> clr_busy high 8 cycles, then clr_done high 1 cycle, then all reads 0x00; we1/wa1=2/wd1=0x77 during busy leaves mem[2]=0x00.
REQ-024 Assert sys_rst_n=0 at ptr=4 mid-sweep -> all outputs 0 at once, clr_busy=0, no clr_done pulse after release.
REQ-025 Hold clr_req high continuously -> back-to-back sweeps: 8 busy cycles, 1 done cycle, 1 IDLE cycle, repeating.
